layer_argmax: RTL

- Downstream consumer of a fully-connected layer.
- Collects the per-neuron outputs of the final layer; each neuron's result is captured when its valid arrives, in any order and at any time.
- Once all scores are captured, scans them sequentially for the signed maximum and presents the winning class index and score on a valid/ready handshake. This is the network's classification result.
- Forwards the layer's overflow flag alongside the result.

---
 rtl/layer_argmax.sv | 112 +++++++++++
 1 files changed

// File: rtl/layer_argmax.sv
// Argmax over the final layer's scores: capture, sequential scan, valid/ready result.
// Optional ARGMAX_THRESHOLD_EN adds THRESHOLD_IN / REJECT_OUT.
module layer_argmax #(
    parameter int NUM_INPUTS = 4,
    parameter int WIDTH      = 8,
    parameter int FRAC_BITS  = 3,
    localparam int IDX_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_INPUTS*WIDTH-1:0] VALUES_IN,
    input  logic [NUM_INPUTS-1:0]       VALIDS_IN,
    input  logic                        OVERFLOW_IN,
`ifdef ARGMAX_THRESHOLD_EN
    input  logic [WIDTH-1:0]            THRESHOLD_IN,
    output logic                        REJECT_OUT,
`endif
    output logic [IDX_WIDTH-1:0]        CLASS_OUT,
    output logic [WIDTH-1:0]            MAX_OUT,
    output logic                        VALID_OUT,
    input  logic                        READY_IN,
    output logic                        OVERFLOW_OUT,
    output logic                        BUSY
);

    if (NUM_INPUTS < 1 || FRAC_BITS < 0 || FRAC_BITS > WIDTH) begin : g_bad_cfg
        $error("layer_argmax: illegal parameter combination");
    end

    typedef enum logic [1:0] {COLLECT, SCAN, HOLD} state_t;

    state_t                state;
    logic [WIDTH-1:0]      score [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] captured;
    logic [NUM_INPUTS-1:0] take;
    logic [IDX_WIDTH-1:0]  ptr;
    logic [WIDTH-1:0]      cand;
    logic [WIDTH-1:0]      next_best;
    logic [IDX_WIDTH-1:0]  next_idx;
    logic                  last;

    always_comb begin
        take      = VALIDS_IN & ~captured;
        cand      = score[ptr];
        last      = (ptr == IDX_WIDTH'(NUM_INPUTS - 1));
        next_best = MAX_OUT;
        next_idx  = CLASS_OUT;
        // Strict compare keeps the earliest index on ties.
        if (ptr == '0 || $signed(cand) > $signed(MAX_OUT)) begin
            next_best = cand;
            next_idx  = ptr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= COLLECT;
            captured     <= '0;
            ptr          <= '0;
            CLASS_OUT    <= '0;
            MAX_OUT      <= '0;
            VALID_OUT    <= 1'b0;
            OVERFLOW_OUT <= 1'b0;
            BUSY         <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) score[i] <= '0;
`ifdef ARGMAX_THRESHOLD_EN
            REJECT_OUT   <= 1'b0;
`endif
        end else begin
            unique case (state)
                COLLECT: begin
                    for (int i = 0; i < NUM_INPUTS; i++)
                        if (take[i]) score[i] <= VALUES_IN[i*WIDTH +: WIDTH];
                    captured     <= captured | take;
                    OVERFLOW_OUT <= OVERFLOW_OUT | OVERFLOW_IN;
                    if (&(captured | take)) begin
                        state <= SCAN;
                        ptr   <= '0;
                        BUSY  <= 1'b1;
                    end
                end
                SCAN: begin
                    MAX_OUT   <= next_best;
                    CLASS_OUT <= next_idx;
                    if (last) begin
                        state     <= HOLD;
                        VALID_OUT <= 1'b1;
`ifdef ARGMAX_THRESHOLD_EN
                        REJECT_OUT <= $signed(next_best) < $signed(THRESHOLD_IN);
`endif
                    end else begin
                        ptr <= ptr + IDX_WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (READY_IN) begin
                        state        <= COLLECT;
                        VALID_OUT    <= 1'b0;
                        captured     <= '0;
                        OVERFLOW_OUT <= 1'b0;
                        BUSY         <= 1'b0;
`ifdef ARGMAX_THRESHOLD_EN
                        REJECT_OUT   <= 1'b0;
`endif
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
